tow_round_arbiter: RTL and testbench
====================================

Name: tow_round_arbiter

Overview:
- Sequences a single tug-of-war reaction round and arbitrates the two players' pushes.
- Flow: on a start request it waits a random number of slowen ticks, lights the LEDs, then awards the round to whichever side pushes first.
- Also detects false starts (early pushes), exact ties and timeouts.
- Sits between the pushbutton sync/one-pulse stage and the scorer/MC. It consumes slowen from Div256 and a random value from lfsr.

Parameters:
- MIN_DELAY, 2: minimum slowen ticks from start to LEDs on (1..15).
- TIMEOUT_TICKS, 8: slowen ticks LEDs stay lit before the round is declared a tie (1..31).
- RAND_W, 4: width of rand_delay.

Ports:
- clk  in  1  system clock (500 Hz divided clock).
- rst  in  1  asynchronous, active-low reset.
- slowen  in  1  one-cycle tick enable from Div256.
- start_rnd  in  1  one-cycle round start request from MC.
- rand_delay  in  RAND_W  random delay value from lfsr; sampled only on an accepted start.
- pbl_p  in  1  left push, synchronized one-cycle pulse.
- pbr_p  in  1  right push, synchronized one-cycle pulse.
- leds_on  out  1  high while in LIT.
- busy  out  1  high in ARM, LIT or DONE.
- winl  out  1  one-cycle pulse: left wins.
- winr  out  1  one-cycle pulse: right wins.
- tie  out  1  one-cycle pulse: simultaneous push, double foul, or timeout.
- foul  out  1  one-cycle pulse qualifying winl/winr: the win came from the opponent's false start.
- round_done  out  1  one-cycle pulse, coincident with any result pulse.

Behaviour:
- Reset (async, rst=0): state=IDLE, cnt=0. All outputs are 0.
- All outputs are registered.
- States: IDLE, ARM, LIT, DONE. Exactly one result class (winl, winr or tie) pulses per round, and only in DONE.
- IDLE:
  - On start_rnd=1, go to ARM and load cnt = MIN_DELAY + rand_delay. Width is 5 bits and cannot overflow with the defaults.
  - Pushes in IDLE are ignored.
- ARM:
  - pbl_p alone: false start by left. Go to DONE with winr=1, foul=1.
  - pbr_p alone: false start by right. Go to DONE with winl=1, foul=1.
  - Both pushes in the same cycle: go to DONE with tie=1, foul=1.
  - Otherwise, on slowen: if cnt==1, go to LIT and load cnt=TIMEOUT_TICKS; else decrement cnt.
  - A push beats slowen when both occur in the same cycle.
- LIT:
  - leds_on=1 from the first LIT cycle, i.e. the cycle after the final ARM slowen tick.
  - pbl_p alone: go to DONE with winl=1. pbr_p alone: go to DONE with winr=1. Both: go to DONE with tie=1.
  - Otherwise, on slowen: if cnt==1, go to DONE with tie=1 (timeout); else decrement cnt.
  - A push beats a coincident final slowen.
- DONE:
  - Lasts exactly one cycle. The result pulses and round_done are asserted here, then the state returns to IDLE.
  - leds_on=0 in DONE.
- start_rnd in ARM, LIT or DONE is ignored; it is not queued.
- Pushes arriving in DONE are ignored.
- Latency: start_rnd at cycle t gives busy=1 at t+1. A push in LIT at cycle t gives the result pulse at t+1.
- Reset asserted mid-round returns to IDLE immediately. No result pulse is emitted.

Decomposition:
- Shared package tow_pkg:
  - State encoding localparams: IDLE=2'd0, ARM=2'd1, LIT=2'd2, DONE=2'd3.
  - MIN_DELAY and TIMEOUT_TICKS defaults.
  - CNT_W=5.
- One natural sub-module: tow_tick_counter, a loadable down-counter with slowen enable and an is_one flag, reused for both the ARM and LIT phases.
- FSM and result registers stay in tow_round_arbiter.

Test Plan:
- Start with rand_delay=3, MIN_DELAY=2, then pbr_p 2 cycles after leds_on rises:
  - leds_on rises the cycle after the 5th slowen.
  - winr=1 and round_done=1 one cycle after pbr_p; foul=0; busy falls the following cycle.
- pbl_p during ARM after 1 slowen -> next cycle winr=1, foul=1, round_done=1; leds_on never asserts.
- pbl_p and pbr_p in the same cycle during LIT -> next cycle tie=1, winl=0, winr=0, foul=0.
- No pushes after LEDs light (TIMEOUT_TICKS=8) -> tie=1 the cycle after the 8th LIT slowen.
- pbl_p coincident with the final LIT slowen -> winl=1, not tie.
- Reset during LIT -> leds_on=0 and busy=0 immediately, no pulses follow. start_rnd asserted during ARM is ignored: exactly one round_done per accepted start.

Source files
------------

// File: rtl/tow_pkg.sv
// rtl/tow_pkg.sv - shared types and defaults for the tug-of-war round arbiter
package tow_pkg;

  localparam int CNT_W             = 5;
  localparam int MIN_DELAY_DEF     = 2;
  localparam int TIMEOUT_TICKS_DEF = 8;
  localparam int RAND_W_DEF        = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_LIT  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    ARM  = ST_ARM,
    LIT  = ST_LIT,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/tow_tick_counter.sv
// rtl/tow_tick_counter.sv - loadable slowen-driven down-counter with is_one flag
module tow_tick_counter
  import tow_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             is_one_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign is_one_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/tow_round_arbiter.sv
// rtl/tow_round_arbiter.sv - round sequencer: random arm delay, LED window, push arbitration
module tow_round_arbiter
  import tow_pkg::*;
#(
  parameter int MIN_DELAY     = MIN_DELAY_DEF,
  parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF,
  parameter int RAND_W        = RAND_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              slowen,
  input  logic              start_rnd,
  input  logic [RAND_W-1:0] rand_delay,
  input  logic              pbl_p,
  input  logic              pbr_p,
  output logic              leds_on,
  output logic              busy,
  output logic              winl,
  output logic              winr,
  output logic              tie,
  output logic              foul,
  output logic              round_done
);

  localparam logic [CNT_W-1:0] MIN_CNT     = CNT_W'(MIN_DELAY);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_TICKS);

  state_t           state_q, state_d;
  logic             cnt_load, cnt_dec, cnt_is_one;
  logic [CNT_W-1:0] cnt_load_val;
  logic             winl_d, winr_d, tie_d, foul_d;
  logic             leds_on_q, busy_q, winl_q, winr_q, tie_q, foul_q, round_done_q;

  tow_tick_counter u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .is_one_o   (cnt_is_one)
  );

  // Pushes are tested before slowen so a push always beats a coincident tick.
  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    winl_d       = 1'b0;
    winr_d       = 1'b0;
    tie_d        = 1'b0;
    foul_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_rnd) begin
          state_d      = ARM;
          cnt_load     = 1'b1;
          cnt_load_val = MIN_CNT + CNT_W'(rand_delay);
        end
      end
      ARM: begin
        if (pbl_p && pbr_p) begin
          state_d = DONE;
          tie_d   = 1'b1;
          foul_d  = 1'b1;
        end else if (pbl_p) begin
          state_d = DONE;
          winr_d  = 1'b1;
          foul_d  = 1'b1;
        end else if (pbr_p) begin
          state_d = DONE;
          winl_d  = 1'b1;
          foul_d  = 1'b1;
        end else if (slowen) begin
          if (cnt_is_one) begin
            state_d      = LIT;
            cnt_load     = 1'b1;
            cnt_load_val = TIMEOUT_CNT;
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      LIT: begin
        if (pbl_p && pbr_p) begin
          state_d = DONE;
          tie_d   = 1'b1;
        end else if (pbl_p) begin
          state_d = DONE;
          winl_d  = 1'b1;
        end else if (pbr_p) begin
          state_d = DONE;
          winr_d  = 1'b1;
        end else if (slowen) begin
          if (cnt_is_one) begin
            state_d = DONE;
            tie_d   = 1'b1;
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from next-state so they line up with state_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      leds_on_q    <= 1'b0;
      busy_q       <= 1'b0;
      winl_q       <= 1'b0;
      winr_q       <= 1'b0;
      tie_q        <= 1'b0;
      foul_q       <= 1'b0;
      round_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      leds_on_q    <= (state_d == LIT);
      busy_q       <= (state_d != IDLE);
      winl_q       <= winl_d;
      winr_q       <= winr_d;
      tie_q        <= tie_d;
      foul_q       <= foul_d;
      round_done_q <= winl_d | winr_d | tie_d;
    end
  end

  assign leds_on    = leds_on_q;
  assign busy       = busy_q;
  assign winl       = winl_q;
  assign winr       = winr_q;
  assign tie        = tie_q;
  assign foul       = foul_q;
  assign round_done = round_done_q;

endmodule

// File: tb/tb_tow_round_arbiter.sv
// tb/tb_tow_round_arbiter.sv - directed self-checking bench for tow_round_arbiter
module tb_tow_round_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       slowen;
  logic       start_rnd;
  logic [3:0] rand_delay;
  logic       pbl_p;
  logic       pbr_p;
  logic       leds_on, busy, winl, winr, tie, foul, round_done;

  int checks = 0;
  int errors = 0;
  int rd_cnt;

  tow_round_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .slowen     (slowen),
    .start_rnd  (start_rnd),
    .rand_delay (rand_delay),
    .pbl_p      (pbl_p),
    .pbr_p      (pbr_p),
    .leds_on    (leds_on),
    .busy       (busy),
    .winl       (winl),
    .winr       (winr),
    .tie        (tie),
    .foul       (foul),
    .round_done (round_done)
  );

  always #5 clk = ~clk;

  // Output vector order: {leds_on, busy, winl, winr, tie, foul, round_done}
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [6:0] exp);
    chk(tag, {25'd0, leds_on, busy, winl, winr, tie, foul, round_done}, {25'd0, exp});
  endtask

  task automatic cyc(input logic s, input logic st, input logic pl, input logic pr);
    slowen    = s;
    start_rnd = st;
    pbl_p     = pl;
    pbr_p     = pr;
    @(posedge clk);
    #1;
    slowen    = 1'b0;
    start_rnd = 1'b0;
    pbl_p     = 1'b0;
    pbr_p     = 1'b0;
  endtask

  task automatic arm_to_lit(input logic [3:0] rd);
    rand_delay = rd;
    cyc(0, 1, 0, 0);
    for (int i = 0; i < int'(rd) + 2; i++) cyc(1, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b0; slowen = 1'b0; start_rnd = 1'b0; rand_delay = 4'd0; pbl_p = 1'b0; pbr_p = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_out("reset_outputs", 7'b0000000);
    rst = 1'b1;
    cyc(0, 0, 1, 1);
    chk_out("idle_push_ignored", 7'b0000000);

    // Round 1: delay 2+3 = 5 ticks, right pushes 2 cycles after LEDs
    rand_delay = 4'd3;
    cyc(0, 1, 0, 0);
    chk_out("s1_busy_after_start", 7'b0100000);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
    chk_out("s1_arm_after_4_ticks", 7'b0100000);
    cyc(1, 0, 0, 0);
    chk_out("s1_lit_after_5_ticks", 7'b1100000);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk_out("s1_lit_hold", 7'b1100000);
    cyc(0, 0, 0, 1);
    chk_out("s1_winr", 7'b0101001);
    cyc(0, 0, 0, 0);
    chk_out("s1_idle", 7'b0000000);

    // False start by left after one ARM tick
    rand_delay = 4'd0;
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    chk_out("s2_arm", 7'b0100000);
    cyc(0, 0, 1, 0);
    chk_out("s2_left_foul", 7'b0101011);
    cyc(0, 0, 0, 0);
    chk_out("s2_idle", 7'b0000000);

    // Right push beats the final ARM slowen
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 1);
    chk_out("s2b_right_foul_beats_tick", 7'b0110011);
    cyc(0, 0, 0, 0);

    // Double foul in ARM
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 1);
    chk_out("s2c_double_foul", 7'b0100111);
    cyc(0, 0, 0, 0);

    // Simultaneous push in LIT
    arm_to_lit(4'd0);
    chk_out("s3_lit", 7'b1100000);
    cyc(0, 0, 1, 1);
    chk_out("s3_tie", 7'b0100101);
    cyc(0, 0, 0, 0);
    chk_out("s3_idle", 7'b0000000);

    // Timeout after 8 LIT ticks
    arm_to_lit(4'd0);
    for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0);
    chk_out("s4_lit_after_7", 7'b1100000);
    cyc(1, 0, 0, 0);
    chk_out("s4_timeout_tie", 7'b0100101);
    cyc(0, 0, 0, 0);

    // Left push coincident with final LIT tick
    arm_to_lit(4'd0);
    for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 0);
    chk_out("s5_winl_beats_timeout", 7'b0110001);
    cyc(0, 0, 0, 0);

    // Async reset during LIT
    arm_to_lit(4'd0);
    chk_out("s6_lit", 7'b1100000);
    #2;
    rst = 1'b0;
    #1;
    chk_out("s6_async_reset", 7'b0000000);
    @(posedge clk); #1;
    rst = 1'b1;
    cyc(1, 0, 1, 1);
    chk_out("s6_no_pulse_1", 7'b0000000);
    cyc(1, 0, 0, 0);
    chk_out("s6_no_pulse_2", 7'b0000000);

    // Restart during ARM and in DONE is ignored
    rand_delay = 4'd1;
    cyc(0, 1, 0, 0);
    rand_delay = 4'd5;
    cyc(0, 1, 0, 0);
    chk_out("s7_arm_restart_ignored", 7'b0100000);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk_out("s7_arm_after_2", 7'b0100000);
    cyc(1, 0, 0, 0);
    chk_out("s7_lit_after_3", 7'b1100000);
    rd_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 0, 0);
      rd_cnt += int'(round_done);
    end
    chk_out("s7_timeout", 7'b0100101);
    cyc(0, 1, 0, 0);
    rd_cnt += int'(round_done);
    chk_out("s7_done_start_ignored", 7'b0000000);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0, 0);
      rd_cnt += int'(round_done);
    end
    chk("s7_one_round_done", 32'(rd_cnt), 32'd1);
    chk_out("s7_idle", 7'b0000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
